// File: rtl/aes_state_fifo.sv
// First-word-fall-through FIFO holding whole AES states (NWORDS x WORD_W) per slot.
// Pointers wrap naturally because DEPTH is a power of two; CLR also scrubs storage.
module aes_state_fifo #(
   parameter int WORD_W = 32,
   parameter int NWORDS = 4,
   parameter int DEPTH  = 4
) (
   input  logic                           CLK,
   input  logic                           CLR,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [NWORDS-1:0][WORD_W-1:0]  state_i,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [NWORDS-1:0][WORD_W-1:0]  state_o,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           full,
   output logic                           empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [NWORDS-1:0][WORD_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]                 wptr_q, wptr_d;
   logic [PW-1:0]                 rptr_q, rptr_d;
   logic [CW-1:0]                 count_q, count_d;
   logic                          push, pop;

   // Status comes only from the count register, so in_ready never sees out_ready.
   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign in_ready  = ~full;
   assign out_valid = ~empty;
   assign count     = count_q;
   assign state_o   = mem_q[rptr_q];

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) mem_q[wptr_q] <= state_i;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

endmodule
